// File: rtl/rr_mux_select_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_select_ctrl_pkg
//   Shared definitions for the round-robin mux select controller: channel and
//   select widths, FSM state encodings, the registered output payload, and
//   small helpers for channel index arithmetic.
// -----------------------------------------------------------------------------
package rr_mux_select_ctrl_pkg;

    // Number of mux inputs (A/B/C/D) and width of the binary select.
    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Registered output bundle driven to the mux select and capture logic.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             sel_valid;
        logic [N_CH-1:0]  grant;
        logic             done;
    } sel_out_t;

    // One-hot of a channel index.
    function automatic logic [N_CH-1:0] ch_onehot(input logic [SEL_W-1:0] idx);
        ch_onehot = N_CH'(1) << idx;
    endfunction

    // Channel pointer addition; wraps naturally modulo N_CH (3+1 -> 0).
    function automatic logic [SEL_W-1:0] ptr_add(input logic [SEL_W-1:0] p,
                                                 input logic [SEL_W-1:0] k);
        ptr_add = p + k;
    endfunction

endpackage : rr_mux_select_ctrl_pkg

// File: rtl/rr_mux_select_ctrl_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin picker. Searches req starting one past the
//   last granted channel and wrapping around, so last_ptr itself is checked
//   last.
// Ports
//   req       in   N_CH   per-channel request
//   last_ptr  in   SEL_W  most recently granted channel
//   pick      out  SEL_W  first requesting channel after last_ptr (0 if none)
//   any       out  1      at least one request present
// -----------------------------------------------------------------------------
module rr_priority_pick
    import rr_mux_select_ctrl_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    // Walk offsets 1..N_CH from last_ptr; first hit wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = ptr_add(last_ptr, SEL_W'(k));
            if (!any && req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule : rr_priority_pick

// File: rtl/rr_mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// rr_mux_select_ctrl
//   Select generator for a 4-to-1 data mux. Arbitrates four channel requests
//   round-robin, drives the 2-bit mux select, holds it for DWELL cycles (or
//   until the granted request drops), then releases with a one-cycle guard
//   gap before the next grant. All outputs are registered.
// Parameters
//   DWELL  cycles a granted select is held (1..2**CNT_W-1; 0 behaves as 1)
//   CNT_W  dwell counter width
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous active-high reset
//   req        in   4  per-channel request (bit i = mux input i)
//   sel        out  2  mux select, binary channel index
//   sel_valid  out  1  high while sel is a granted, stable select
//   grant      out  4  one-hot of granted channel, 0 when sel_valid low
//   done       out  1  one-cycle pulse following a grant release
// -----------------------------------------------------------------------------
module rr_mux_select_ctrl
    import rr_mux_select_ctrl_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic [N_CH-1:0]  grant,
    output logic             done
);

    // A zero dwell would never release on count; treat it as one cycle.
    localparam int unsigned DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_EFF - 1);

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
    sel_out_t         out_q,      out_d;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic             release_c;

    // Round-robin candidate for the next grant.
    rr_priority_pick u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .pick     (pick),
        .any      (any)
    );

    // Release on dwell expiry or when the granted channel drops its request;
    // both together still give a single release.
    assign release_c = (cnt_q == CNT_LAST) || !req[out_q.sel];

    // State, counter, pointer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            last_ptr_q      <= SEL_W'(N_CH - 1);
            out_q.sel       <= '0;
            out_q.sel_valid <= 1'b0;
            out_q.grant     <= '0;
            out_q.done      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ptr_q <= last_ptr_d;
            out_q      <= out_d;
        end
    end

    // Next-state and next-output logic. sel is never cleared outside reset so
    // the mux select does not glitch on release.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_ptr_d      = last_ptr_q;
        out_d           = out_q;
        out_d.sel_valid = 1'b0;
        out_d.grant     = '0;
        out_d.done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d         = ST_GRANT;
                    cnt_d           = '0;
                    out_d.sel       = pick;
                    out_d.sel_valid = 1'b1;
                    out_d.grant     = ch_onehot(pick);
                end
            end

            ST_GRANT: begin
                if (release_c) begin
                    state_d    = ST_GAP;
                    last_ptr_d = out_q.sel;
                    out_d.done = 1'b1;
                end else begin
                    cnt_d           = cnt_q + CNT_W'(1);
                    out_d.sel_valid = 1'b1;
                    out_d.grant     = out_q.grant;
                end
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sel       = out_q.sel;
    assign sel_valid = out_q.sel_valid;
    assign grant     = out_q.grant;
    assign done      = out_q.done;

endmodule : rr_mux_select_ctrl

// File: tb/tb_rr_mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_select_ctrl
//   Bench for rr_mux_select_ctrl: one DWELL=4 instance and one DWELL=1
//   instance share clock and reset. A countdown reference model predicts
//   each instance's outputs for the next edge and queues them; the queued
//   values are popped and compared after the edge. Directed sections also
//   check grant order and grant period.
// -----------------------------------------------------------------------------
module tb_rr_mux_select_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req0, req1;
    logic [1:0] sel0, sel1;
    logic       sel_valid0, sel_valid1;
    logic [3:0] grant0, grant1;
    logic       done0, done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    rr_mux_select_ctrl #(.DWELL(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .req(req0),
        .sel(sel0), .sel_valid(sel_valid0), .grant(grant0), .done(done0)
    );

    rr_mux_select_ctrl #(.DWELL(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1),
        .sel(sel1), .sel_valid(sel_valid1), .grant(grant1), .done(done1)
    );

    // Data mux driven by sel: A/B/C/D.
    logic [7:0] mux_data [4];
    initial begin
        mux_data[0] = 8'hA0; mux_data[1] = 8'hB1;
        mux_data[2] = 8'hC2; mux_data[3] = 8'hD3;
    end

    // Reference model state, one slot per instance.
    int         m_st   [2];
    int         m_left [2];
    int         m_dwell[2];
    logic [1:0] m_ptr  [2];
    logic [1:0] m_sel  [2];
    logic       m_valid[2];
    logic       m_done [2];
    logic [3:0] m_grant[2];

    // Scoreboards: {sel[1:0], valid, done, grant[3:0]}.
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    // Grant start log: channel and cycle of each rising sel_valid.
    int gsel0[$], gcyc0[$], gsel1[$], gcyc1[$];
    logic pv0 = 1'b0, pv1 = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input logic [3:0] r, input logic rst);
        logic [1:0] c;
        logic       found;
        if (rst) begin
            m_st[i] = 0; m_left[i] = 0; m_ptr[i] = 2'd3; m_sel[i] = 2'd0;
            m_valid[i] = 1'b0; m_done[i] = 1'b0; m_grant[i] = 4'd0;
        end else begin
            case (m_st[i])
                0: begin
                    m_done[i] = 1'b0; m_valid[i] = 1'b0; m_grant[i] = 4'd0;
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        c = 2'((int'(m_ptr[i]) + k) % 4);
                        if (!found && r[c]) begin
                            found = 1'b1;
                            m_sel[i] = c;
                        end
                    end
                    if (found) begin
                        m_valid[i] = 1'b1;
                        m_grant[i] = 4'b0001 << m_sel[i];
                        m_left[i]  = m_dwell[i] - 1;
                        m_st[i]    = 1;
                    end
                end
                1: begin
                    if (m_left[i] == 0 || !r[m_sel[i]]) begin
                        m_valid[i] = 1'b0; m_grant[i] = 4'd0; m_done[i] = 1'b1;
                        m_ptr[i] = m_sel[i]; m_st[i] = 2;
                    end else begin
                        m_left[i]--;
                    end
                end
                default: begin
                    m_done[i] = 1'b0; m_st[i] = 0;
                end
            endcase
        end
        if (i == 0) exp_q0.push_back({m_sel[0], m_valid[0], m_done[0], m_grant[0]});
        else        exp_q1.push_back({m_sel[1], m_valid[1], m_done[1], m_grant[1]});
    endtask

    task automatic compare(input int i, input logic [7:0] e, input logic [1:0] s,
                           input logic v, input logic d, input logic [3:0] g);
        check($sformatf("u%0d.sel", i),       8'(s), 8'(e[7:6]));
        check($sformatf("u%0d.sel_valid", i), 8'(v), 8'(e[5]));
        check($sformatf("u%0d.done", i),      8'(d), 8'(e[4]));
        check($sformatf("u%0d.grant", i),     8'(g), 8'(e[3:0]));
        if (e[5]) check($sformatf("u%0d.mux_out", i), mux_data[s], mux_data[e[7:6]]);
    endtask

    // One clock: drive inputs, predict, advance, pop and compare.
    task automatic step(input logic rst, input logic [3:0] r0, input logic [3:0] r1);
        reset = rst; req0 = r0; req1 = r1;
        model_step(0, r0, rst);
        model_step(1, r1, rst);
        @(posedge clk);
        #1;
        cyc++;
        compare(0, exp_q0.pop_front(), sel0, sel_valid0, done0, grant0);
        compare(1, exp_q1.pop_front(), sel1, sel_valid1, done1, grant1);
        if (sel_valid0 && !pv0) begin gsel0.push_back(int'(sel0)); gcyc0.push_back(cyc); end
        if (sel_valid1 && !pv1) begin gsel1.push_back(int'(sel1)); gcyc1.push_back(cyc); end
        pv0 = sel_valid0; pv1 = sel_valid1;
    endtask

    task automatic clear_log();
        gsel0.delete(); gcyc0.delete(); gsel1.delete(); gcyc1.delete();
    endtask

    // Compare logged grant order and spacing for one instance.
    task automatic check_seq(input string tag, input int i, input int exp_sel[], input int period);
        int n;
        n = (i == 0) ? gsel0.size() : gsel1.size();
        check({tag, ".count"}, 8'(n >= exp_sel.size()), 8'd1);
        for (int k = 0; k < exp_sel.size() && k < n; k++) begin
            check($sformatf("%s.sel%0d", tag, k),
                  8'((i == 0) ? gsel0[k] : gsel1[k]), 8'(exp_sel[k]));
            if (k > 0)
                check($sformatf("%s.period%0d", tag, k),
                      8'((i == 0) ? gcyc0[k] - gcyc0[k-1] : gcyc1[k] - gcyc1[k-1]),
                      8'(period));
        end
    endtask

    initial begin
        int s2[], s3[], s6[];
        logic rr;
        m_dwell[0] = 4; m_dwell[1] = 1;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_left[i] = 0; m_ptr[i] = 2'd3; m_sel[i] = 2'd0;
            m_valid[i] = 1'b0; m_done[i] = 1'b0; m_grant[i] = 4'd0;
        end
        reset = 1'b1; req0 = 4'd0; req1 = 4'd0;

        // Reset state.
        step(1'b1, 4'd0, 4'd0);
        step(1'b1, 4'd0, 4'd0);
        check("reset.sel", 8'(sel0), 8'd0);
        check("reset.valid", 8'(sel_valid0), 8'd0);

        // T1: single requester ch0, regrant after dwell + gap.
        clear_log();
        for (int k = 0; k < 14; k++) step(1'b0, 4'b0001, 4'b0001);
        s3 = '{0, 0, 0};
        check_seq("t1", 0, s3, 6);

        // T2: all requesting from reset -> 0,1,2,3,0 every 6 cycles.
        step(1'b1, 4'd0, 4'd0);
        clear_log();
        for (int k = 0; k < 26; k++) step(1'b0, 4'b1111, 4'b1111);
        s2 = '{0, 1, 2, 3, 0};
        check_seq("t2", 0, s2, 6);

        // T3: ch1 granted, then 1010 -> ch3 then ch1.
        step(1'b1, 4'd0, 4'd0);
        clear_log();
        step(1'b0, 4'b0010, 4'b0010);
        for (int k = 0; k < 14; k++) step(1'b0, 4'b1010, 4'b1010);
        s3 = '{1, 3, 1};
        check_seq("t3", 0, s3, 6);

        // T4: early drop of ch2 after two valid cycles.
        step(1'b1, 4'd0, 4'd0);
        step(1'b0, 4'b0100, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        check("t4.valid", 8'(sel_valid0), 8'd0);
        check("t4.done",  8'(done0), 8'd1);
        check("t4.sel",   8'(sel0), 8'd2);
        step(1'b0, 4'b0000, 4'b0000);
        check("t4.done_pulse", 8'(done0), 8'd0);
        check("t4.sel_hold",   8'(sel0), 8'd2);

        // T5: reset mid-grant on ch3, then 1001 -> ch0.
        step(1'b1, 4'd0, 4'd0);
        step(1'b0, 4'b1000, 4'b1000);
        step(1'b0, 4'b1000, 4'b1000);
        step(1'b1, 4'b1000, 4'b1000);
        check("t5.sel",   8'(sel0), 8'd0);
        check("t5.valid", 8'(sel_valid0), 8'd0);
        check("t5.grant", 8'(grant0), 8'd0);
        check("t5.done",  8'(done0), 8'd0);
        step(1'b0, 4'b1001, 4'b1001);
        check("t5.regrant", 8'(grant0), 8'b0000_0001);

        // T6: DWELL=1 instance, 0110 -> alternating 1,2 every 3 cycles.
        step(1'b1, 4'd0, 4'd0);
        clear_log();
        for (int k = 0; k < 12; k++) step(1'b0, 4'b0110, 4'b0110);
        s6 = '{1, 2, 1, 2};
        check_seq("t6", 1, s6, 3);

        // Random traffic with occasional reset.
        for (int k = 0; k < 300; k++) begin
            rr = ($urandom_range(0, 31) == 0);
            step(rr, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_mux_select_ctrl
